// File: rtl/fsm_stim_controller.sv
// Stimulus sequencer for the lab's Moore sequence FSM: resets it, shifts a word
// into x MSB-first, logs every y response and counts the 2'b11 responses.
module fsm_stim_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [1:0]         y_in,
  output logic               fsm_x,
  output logic               fsm_rst,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   hit_count,
  output logic [2*WIDTH-1:0] y_log
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} stateT;

  stateT           state;
  logic [WIDTH-1:0] shReg;
  logic [BW-1:0]    bitCnt;
  logic             captureEn;
  logic [BW-1:0]    captureSlot;

  // The driven FSM is Moore, so its response to a bit shows up one cycle later:
  // SHIFT cycle k logs bit k-1, and DRAIN logs the final bit.
  always_comb begin
    captureEn   = ((state == SHIFT) && (bitCnt != '0)) || (state == DRAIN);
    captureSlot = (state == DRAIN) ? BW'(WIDTH - 1) : (bitCnt - BW'(1));
  end

  assign fsm_rst = rst | (state == CLR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shReg     <= '0;
      bitCnt    <= '0;
      fsm_x     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_count <= '0;
      y_log     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLR;
            shReg     <= data_in;
            bitCnt    <= '0;
            hit_count <= '0;
            y_log     <= '0;
            busy      <= 1'b1;
          end
        end
        CLR: begin
          state <= SHIFT;
          fsm_x <= shReg[WIDTH-1];
          shReg <= {shReg[WIDTH-2:0], 1'b0};
        end
        SHIFT: begin
          if (bitCnt == BW'(WIDTH - 1)) begin
            state <= DRAIN;
            fsm_x <= 1'b0;
          end else begin
            bitCnt <= bitCnt + BW'(1);
            fsm_x  <= shReg[WIDTH-1];
            shReg  <= {shReg[WIDTH-2:0], 1'b0};
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          fsm_x <= 1'b0;
        end
      endcase

      if (captureEn) begin
        y_log[{captureSlot, 1'b0} +: 2] <= y_in;
        if ((y_in == 2'b11) && (hit_count != '1))
          hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fsm_stim_controller.sv
// Bench for fsm_stim_controller: directed scenarios plus random words, checked
// against a per-word expectation built from popcount and bit-to-slot mapping.
module tb_fsm_stim_controller;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int RUN_CYCLES = WIDTH + 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   dataIn;
  logic [1:0]         yIn;
  logic               fsmX;
  logic               fsmRst;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   hitCount;
  logic [2*WIDTH-1:0] yLog;
  logic               xQ;

  int checkCnt = 0;
  int failCnt  = 0;

  fsm_stim_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(dataIn), .y_in(yIn),
    .fsm_x(fsmX), .fsm_rst(fsmRst), .busy(busy), .done(done),
    .hit_count(hitCount), .y_log(yLog)
  );

  always #5 clk = ~clk;

  // Stand-in for the driven Moore FSM: y echoes the last accepted x on both bits.
  always_ff @(posedge clk) xQ <= fsmRst ? 1'b0 : fsmX;
  assign yIn = {xQ, xQ};

  function automatic logic [CNT_W-1:0] expHits(input logic [WIDTH-1:0] w);
    return CNT_W'($countones(w));
  endfunction

  function automatic logic [2*WIDTH-1:0] expLog(input logic [WIDTH-1:0] w);
    logic [2*WIDTH-1:0] l;
    l = '0;
    for (int k = 0; k < WIDTH; k++)
      if (w[WIDTH-1-k]) l[2*k +: 2] = 2'b11;
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] d);
    start  = s;
    dataIn = d;
  endtask

  // One run from a start pulse; optionally pokes start/data_in mid-SHIFT.
  task automatic runWord(input logic [WIDTH-1:0] word, input bit poke, input string tag);
    int n, doneAt, rstCycles;
    bit xSeen;
    applyStimulus(1'b1, word);
    @(negedge clk);
    applyStimulus(1'b0, word);
    n = 1; doneAt = 0; rstCycles = 0; xSeen = 0;
    while (n <= 40) begin
      if (fsmRst) rstCycles++;
      if (fsmX) xSeen = 1;
      if (done) begin doneAt = n; break; end
      if (poke && n == 4) applyStimulus(1'b1, '0);
      else applyStimulus(1'b0, poke ? '0 : word);
      @(negedge clk);
      n++;
    end
    applyStimulus(1'b0, '0);
    checkOutput({tag, " doneCycle"}, doneAt, RUN_CYCLES);
    checkOutput({tag, " hitCount"}, 32'(hitCount), 32'(expHits(word)));
    checkOutput({tag, " yLog"}, 32'(yLog), 32'(expLog(word)));
    checkOutput({tag, " busyInDone"}, 32'(busy), 0);
    checkOutput({tag, " fsmRstCycles"}, rstCycles, 1);
    checkOutput({tag, " xActivity"}, 32'(xSeen), 32'(word != '0));
    @(negedge clk);
    checkOutput({tag, " donePulse"}, 32'(done), 0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    checkOutput({tag, " idleAfter"}, 32'(busy), 0);
    checkOutput({tag, " hitHold"}, 32'(hitCount), 32'(expHits(word)));
  endtask

  initial begin
    int doneCycles[$];
    logic [WIDTH-1:0] w;
    bit doneSeen;

    $display("[TB] reset");
    rst = 1'b1;
    applyStimulus(1'b0, '0);
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset fsmX", 32'(fsmX), 0);
    checkOutput("reset fsmRst", 32'(fsmRst), 1);
    checkOutput("reset hitCount", 32'(hitCount), 0);
    checkOutput("reset yLog", 32'(yLog), 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle fsmRst", 32'(fsmRst), 0);

    $display("[TB] directed words");
    runWord(8'hB2, 1'b0, "B2");
    runWord(8'hFF, 1'b0, "FF");
    runWord(8'h00, 1'b0, "00");
    runWord(8'hB2, 1'b1, "pokeDuringShift");

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 8'hB2);
    @(negedge clk);
    for (int n = 1; n <= 36; n++) begin
      if (done) begin
        doneCycles.push_back(n);
        checkOutput("b2b hitCount", 32'(hitCount), 32'(expHits(8'hB2)));
        checkOutput("b2b yLog", 32'(yLog), 32'(expLog(8'hB2)));
      end
      if (n == 36) applyStimulus(1'b0, '0);
      else @(negedge clk);
    end
    checkOutput("b2b pulses", doneCycles.size(), 3);
    if (doneCycles.size() == 3) begin
      checkOutput("b2b first", doneCycles[0], RUN_CYCLES);
      checkOutput("b2b period1", doneCycles[1] - doneCycles[0], WIDTH + 4);
      checkOutput("b2b period2", doneCycles[2] - doneCycles[1], WIDTH + 4);
    end
    repeat (3) @(negedge clk);
    checkOutput("b2b stopped", 32'(busy), 0);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 8'hB2);
    @(negedge clk);
    applyStimulus(1'b0, 8'hB2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort done", 32'(done), 0);
    checkOutput("abort hitCount", 32'(hitCount), 0);
    checkOutput("abort yLog", 32'(yLog), 0);
    checkOutput("abort fsmRst", 32'(fsmRst), 1);
    checkOutput("abort fsmX", 32'(fsmX), 0);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) doneSeen = 1;
    end
    checkOutput("abort noDone", 32'(doneSeen), 0);
    runWord(8'hFF, 1'b0, "afterAbort");

    $display("[TB] random words");
    for (int r = 0; r < 8; r++) begin
      w = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      runWord(w, r[0], $sformatf("rand%0d_%h", r, w));
    end

    $display("%0d/%0d checks passed", checkCnt - failCnt, checkCnt);
    $finish;
  end

endmodule
